lsu_align: RTL and testbench

- Memory-access stage load/store unit that sits directly upstream of the byte-lane data memory (32-bit word port, 4-bit byte write enable, combinational read, write on posedge clk).
- Converts the EX/MEM request (funct3, byte address, rs2 data) into word-aligned memory accesses with byte enables and lane-shifted write data.
- Extracts, merges and sign/zero-extends load data.
- Splits misaligned accesses into two sequential word accesses and stalls the pipeline for the extra cycle.

---
 rtl/lsu_align.sv | 187 ++++++++++++++++++
 tb/tb_lsu_align.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// Memory-stage load/store aligner for a byte-lane data memory.
// Misaligned accesses are split into two word accesses with one stall cycle.
module lsu_align #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_we,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      rdata,
    output logic             done,
    output logic             stall,
    output logic             fault,
    output logic [CNT_W-1:0] misalign_cnt
);

    typedef enum logic {
        S_IDLE,
        S_SECOND
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_lo;
    logic [CNT_W-1:0] r_cnt;

    logic             w_legal;
    logic             w_sext;
    logic [2:0]       w_nb;
    logic [1:0]       w_off;
    logic [1:0]       w_inv;
    logic [3:0]       w_end;
    logic             w_mis;
    logic [3:0]       w_mask;
    logic [7:0]       w_be8;
    logic [63:0]      w_wd64;
    logic [31:0]      w_addr_a;
    logic [31:0]      w_addr_b;
    logic [31:0]      w_rd_lo;
    logic [31:0]      w_merged;
    logic [31:0]      w_raw;
    logic [31:0]      w_ext;
    logic             w_cap;

    always_comb begin
        w_legal = 1'b0;
        w_sext  = 1'b0;
        w_nb    = 3'd0;
        case (funct3)
            3'b000: begin
                w_legal = 1'b1;
                w_sext  = 1'b1;
                w_nb    = 3'd1;
            end
            3'b001: begin
                w_legal = 1'b1;
                w_sext  = 1'b1;
                w_nb    = 3'd2;
            end
            3'b010: begin
                w_legal = 1'b1;
                w_nb    = 3'd4;
            end
            3'b100: begin
                w_legal = !req_we;
                w_nb    = 3'd1;
            end
            3'b101: begin
                w_legal = !req_we;
                w_nb    = 3'd2;
            end
            default: ;
        endcase
    end

    assign w_off    = addr[1:0];
    assign w_inv    = 2'd0 - w_off;
    assign w_end    = {2'b00, w_off} + {1'b0, w_nb};
    assign w_mis    = (w_end > 4'd4);
    assign w_addr_a = {addr[31:2], 2'b00};
    assign w_addr_b = w_addr_a + 32'd4;

    always_comb begin
        w_mask = 4'h0;
        case (w_nb)
            3'd1:    w_mask = 4'h1;
            3'd2:    w_mask = 4'h3;
            3'd4:    w_mask = 4'hF;
            default: w_mask = 4'h0;
        endcase
    end

    // Upper nibble/word of the shifted values feed the second access.
    assign w_be8    = {4'h0, w_mask} << w_off;
    assign w_wd64   = {32'h0, wdata} << {w_off, 3'b000};
    assign w_rd_lo  = mem_rdata >> {w_off, 3'b000};
    assign w_merged = r_lo | (mem_rdata << {w_inv, 3'b000});
    assign w_raw    = (r_state == S_SECOND) ? w_merged : w_rd_lo;

    always_comb begin
        w_ext = w_raw;
        case (w_nb)
            3'd1: w_ext = w_sext ? {{24{w_raw[7]}}, w_raw[7:0]}
                                 : {24'h0, w_raw[7:0]};
            3'd2: w_ext = w_sext ? {{16{w_raw[15]}}, w_raw[15:0]}
                                 : {16'h0, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_cap     = 1'b0;
        mem_addr  = w_addr_a;
        mem_wdata = 32'h0;
        mem_we    = 4'h0;
        rdata     = 32'h0;
        done      = 1'b0;
        stall     = 1'b0;
        fault     = 1'b0;
        // While reset is held the memory port stays quiet.
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (!w_legal) begin
                            fault = 1'b1;
                            done  = 1'b1;
                        end else begin
                            if (req_we) begin
                                mem_we    = w_be8[3:0];
                                mem_wdata = w_wd64[31:0];
                            end
                            if (w_mis) begin
                                stall  = 1'b1;
                                w_cap  = 1'b1;
                                w_next = S_SECOND;
                            end else begin
                                done = 1'b1;
                                if (!req_we) rdata = w_ext;
                            end
                        end
                    end
                end
                S_SECOND: begin
                    w_next = S_IDLE;
                    if (req_valid) begin
                        mem_addr = w_addr_b;
                        done     = 1'b1;
                        if (req_we) begin
                            mem_we    = w_be8[7:4];
                            mem_wdata = w_wd64[63:32];
                        end else begin
                            rdata = w_ext;
                        end
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_lo    <= 32'h0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_cap) begin
                r_lo <= w_rd_lo;
                if (r_cnt != {CNT_W{1'b1}})
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign misalign_cnt = r_cnt;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a byte-lane memory model.
module tb_lsu_align;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] rdata;
    logic        done;
    logic        stall;
    logic        fault;
    logic [15:0] misalign_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [0:1023];

    lsu_align #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .rdata        (rdata),
        .done         (done),
        .stall        (stall),
        .fault        (fault),
        .misalign_cnt (misalign_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i])
                mem[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = d;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        #2;
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        check("rst_we", mem_we, 0);
        check("rst_cnt", misalign_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        put(1, 3'b010, 32'h100, 32'hDEADBEEF);
        check("sw_we", mem_we, 4'hF);
        check("sw_addr", mem_addr, 32'h100);
        check("sw_stall", stall, 0);
        check("sw_done", done, 1);
        put(0, 3'b010, 32'h100, 32'h0);
        check("lw_rdata", rdata, 32'hDEADBEEF);

        put(1, 3'b000, 32'h203, 32'h000000A5);
        check("sb_we", mem_we, 4'b1000);
        check("sb_wd", mem_wdata, 32'hA5000000);
        put(0, 3'b000, 32'h203, 32'h0);
        check("lb_rdata", rdata, 32'hFFFFFFA5);
        put(0, 3'b100, 32'h203, 32'h0);
        check("lbu_rdata", rdata, 32'h000000A5);

        put(1, 3'b010, 32'h301, 32'h11223344);
        check("msw1_addr", mem_addr, 32'h300);
        check("msw1_we", mem_we, 4'b1110);
        check("msw1_wd", mem_wdata, 32'h22334400);
        check("msw1_stall", stall, 1);
        check("msw1_done", done, 0);
        step();
        check("msw2_addr", mem_addr, 32'h304);
        check("msw2_we", mem_we, 4'b0001);
        check("msw2_wd", mem_wdata[7:0], 32'h11);
        check("msw2_done", done, 1);
        check("msw2_stall", stall, 0);
        put(0, 3'b010, 32'h301, 32'h0);
        check("mlw1_stall", stall, 1);
        step();
        check("mlw2_rdata", rdata, 32'h11223344);
        check("mlw2_cnt", misalign_cnt, 2);

        put(0, 3'b001, 32'h303, 32'h0);
        check("mlh1_stall", stall, 1);
        step();
        check("mlh2_rdata", rdata, 32'h00001122);
        check("mlh2_cnt", misalign_cnt, 3);
        put(1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF);
        check("wsh1_addr", mem_addr, 32'hFFFFFFFC);
        check("wsh1_we", mem_we, 4'b1000);
        check("wsh1_wd", mem_wdata, 32'hEF000000);
        step();
        check("wsh2_addr", mem_addr, 32'h0);
        check("wsh2_we", mem_we, 4'b0001);
        check("wsh2_wd", mem_wdata[7:0], 32'hBE);
        check("wsh2_cnt", misalign_cnt, 4);

        put(1, 3'b010, 32'h401, 32'h55667788);
        check("rsw1_we", mem_we, 4'b1110);
        step();
        check("rsw2_we", mem_we, 4'b0001);
        rst_n = 1'b0;
        #1;
        check("rst2_we", mem_we, 0);
        check("rst2_stall", stall, 0);
        check("rst2_done", done, 0);
        check("rst2_cnt", misalign_cnt, 0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        put(0, 3'b010, 32'h404, 32'h0);
        check("lw404", rdata, 32'h0);
        check("lw404_stall", stall, 0);
        put(0, 3'b010, 32'h400, 32'h0);
        check("lw400", rdata, 32'h66778800);

        put(1, 3'b011, 32'h500, 32'hCAFEF00D);
        check("ill_we", mem_we, 0);
        check("ill_fault", fault, 1);
        check("ill_done", done, 1);
        check("ill_stall", stall, 0);
        put(0, 3'b110, 32'h500, 32'h0);
        check("ill_ld_fault", fault, 1);
        check("ill_ld_rdata", rdata, 0);
        put(0, 3'b010, 32'h500, 32'h0);
        check("lw500", rdata, 32'h0);
        check("lw500_fault", fault, 0);
        check("ill_cnt", misalign_cnt, 0);

        put(0, 3'b101, 32'h102, 32'h0);
        check("lhu_rdata", rdata, 32'h0000DEAD);
        put(0, 3'b001, 32'h102, 32'h0);
        check("lh_rdata", rdata, 32'hFFFFDEAD);

        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("idle_done", done, 0);
        check("idle_rdata", rdata, 0);
        check("idle_we", mem_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
